sprite_dma: RTL and testbench
=============================

Name: sprite_dma

Overview:
- Memory-mapped DMA engine that copies a block of words from program/main memory into sprite object RAM, like a console OAM DMA.
- Sits beside the memory map decoder on the CPU data bus. It owns port A of main memory and the sprite object RAM write port while a transfer runs, and stalls the CPU for that time.
- It can defer the copy until vertical blank, so sprite tables are updated without tearing.

Parameters:
- SRC_ADDR, 16'h4803, address of the 16-bit source start register (byte-free word address into main memory).
- DST_ADDR, 16'h4804, address of the 10-bit sprite object RAM destination register.
- LEN_ADDR, 16'h4805, address of the 11-bit length register (words, 0..1024).
- CTRL_ADDR, 16'h4806, address of the control/status register.
- SPRITE_DEPTH_BITS, 10, sprite object RAM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- memaddr  in  16  CPU data address
- memwrite  in  1  CPU write strobe
- writedata  in  16  CPU write data
- dma_memdata  out  16  registered readback of DMA registers; 0 when no DMA address is selected
- vbright  in  1  1 = active display; vblank = !vbright
- stall  out  1  holds CPU pipeline; DMA owns the buses
- busy  out  1  transfer pending or active
- mem_addr  out  16  main memory port A address while stall = 1
- mem_en  out  1  main memory port A enable (DMA side)
- mem_rdata  in  16  main memory port A data, 1-cycle synchronous read latency
- sprite_addr  out  10  sprite object RAM address
- sprite_we  out  1  sprite object RAM write enable
- sprite_wdata  out  16  sprite object RAM write data
- done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (rst = 0 at a clk edge): all registers and outputs go to 0, state = IDLE. This applies mid-transfer too: it aborts immediately, with no further sprite writes and no done pulse.
- Register writes (memwrite with a matching memaddr) are accepted only in IDLE:
  - SRC takes writedata[15:0].
  - DST takes writedata[9:0].
  - LEN takes writedata[10:0], clamped to 1024 if larger.
- CTRL write bits:
  - bit0 = start.
  - bit1 = wait_vblank.
  - bit2 = abort; honoured only in WAIT_VB.
- Readback: dma_memdata is updated every clk from memaddr, with the same 1-cycle latency as the other memory-mapped registers.
  - SRC, DST and LEN read back zero-extended.
  - CTRL reads {13'b0, wait_vblank_latched, 1'b0, busy}.
  - Any other address reads 0.
- FSM states: IDLE, WAIT_VB, PRIME, STREAM, FINISH.
- IDLE:
  - start with LEN = 0 -> FINISH.
  - start with wait_vblank = 1 -> WAIT_VB.
  - otherwise -> PRIME.
- WAIT_VB:
  - busy = 1, stall = 0.
  - Moves to PRIME on the first clk where vbright = 0.
  - A CTRL write with bit2 = 1 returns to IDLE with no done pulse.
- PRIME (1 cycle):
  - stall = 1, mem_en = 1, mem_addr = src.
  - The internal word counter is loaded with LEN.
- STREAM (LEN cycles):
  - Cycle k (k = 0..LEN-1): sprite_we = 1, sprite_addr = dst + k, sprite_wdata = mem_rdata, which is the word read at src + k.
  - In the same cycle mem_addr = src + k + 1 and mem_en = 1 while k < LEN-1.
  - After the last write -> FINISH.
- FINISH (1 cycle): done = 1, stall = 0, busy = 0, then -> IDLE.
- Timing for a start write at edge T with no wait and LEN = N ≥ 1:
  - stall is high for cycles T+1 through T+1+N (N+1 cycles).
  - done pulses at T+2+N.
- Timing for LEN = 0: done pulses at T+1; stall never asserts.
- Wrap rules: src increments modulo 2^16; the destination address is modulo 1024 and wraps 1023 -> 0.
- Display activity: vbright rising during PRIME/STREAM does not pause the transfer.
- start while busy is ignored.
- sprite_we is never asserted outside STREAM.

Decomposition:
- Shared package (gpu_pkg): the register address constants (SRC/DST/LEN/CTRL), the CTRL bit indices, the FSM state enum (3-bit), and SPRITE_DEPTH_BITS.
- One natural sub-module: dma_regs. It holds the memory-mapped register file and readback mux, gates writes on busy, and presents src/dst/len/ctrl values to the sprite_dma FSM/datapath.

Test Plan:
- Write SRC=0x0100, DST=0x010, LEN=4, then CTRL=0x1 at T -> stall is high for T+1..T+5; sprite RAM 0x010..0x013 equals main memory 0x0100..0x0103; done pulses at T+6.
- DST=0x3FE, LEN=4 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001.
- CTRL=0x3 with vbright=1 for 50 cycles -> busy=1 and stall=0 throughout; vbright falls at cycle C -> PRIME at C+1; the copy completes correctly.
- LEN=0 and start -> done at T+1; no stall, no sprite_we.
- In WAIT_VB write CTRL=0x4 -> state returns to IDLE, busy=0, no done. Separately, assert rst=0 mid-STREAM -> sprite_we drops the next cycle and all outputs are 0.
- Readback: write LEN=0x7FF -> reading LEN returns 1024. Write SRC during busy -> the value is unchanged. CTRL reads busy=1 during the transfer.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the sprite DMA engine.
// Holds the memory-mapped register addresses, the CTRL bit positions,
// the transfer FSM state encoding, the sprite RAM address width and
// a helper that clamps a requested length to the sprite RAM size.
package gpu_pkg;

  localparam logic [15:0] SRC_ADDR  = 16'h4803;
  localparam logic [15:0] DST_ADDR  = 16'h4804;
  localparam logic [15:0] LEN_ADDR  = 16'h4805;
  localparam logic [15:0] CTRL_ADDR = 16'h4806;

  localparam int SPRITE_DEPTH_BITS = 10;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_WAIT_VB_BIT = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  // A full sprite RAM is the longest useful copy.
  localparam logic [10:0] LEN_MAX = 11'd1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VB = 3'd1,
    ST_PRIME   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_FINISH  = 3'd4
  } dma_state_e;

  function automatic logic [10:0] clamp_len(input logic [10:0] raw);
    logic [10:0] res;
    if (raw > LEN_MAX) begin
      res = LEN_MAX;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_regs.sv
// Memory-mapped register file of the sprite DMA engine.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   memaddr/memwrite/writedata  CPU data bus
//   idle             FSM is idle; register writes are accepted only then
//   busy             transfer pending/active, reported in CTRL readback
//   src/dst/len      programmed transfer parameters
//   wait_vblank      latched CTRL wait-for-vblank bit
//   ctrl_wr          CPU write to CTRL this cycle (any FSM state)
//   dma_memdata      registered readback, 0 for unrelated addresses
module dma_regs
  import gpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  memaddr,
  input  logic                         memwrite,
  input  logic [15:0]                  writedata,
  input  logic                         idle,
  input  logic                         busy,
  output logic [15:0]                  src,
  output logic [SPRITE_DEPTH_BITS-1:0] dst,
  output logic [10:0]                  len,
  output logic                         wait_vblank,
  output logic                         ctrl_wr,
  output logic [15:0]                  dma_memdata
);

  logic [15:0] rd_mux;

  assign ctrl_wr = memwrite && (memaddr == CTRL_ADDR);

  // Register file; parameters are frozen while a transfer is pending or running
  always_ff @(posedge clk) begin
    if (!rst) begin
      src         <= 16'd0;
      dst         <= {SPRITE_DEPTH_BITS{1'b0}};
      len         <= 11'd0;
      wait_vblank <= 1'b0;
    end else if (memwrite && idle) begin
      case (memaddr)
        SRC_ADDR:  src         <= writedata;
        DST_ADDR:  dst         <= writedata[SPRITE_DEPTH_BITS-1:0];
        LEN_ADDR:  len         <= clamp_len(writedata[10:0]);
        CTRL_ADDR: wait_vblank <= writedata[CTRL_WAIT_VB_BIT];
        default:   src         <= src;
      endcase
    end else begin
      src <= src;
    end
  end

  // Readback select for the addressed register
  always_comb begin
    rd_mux = 16'd0;
    case (memaddr)
      SRC_ADDR:  rd_mux = src;
      DST_ADDR:  rd_mux = {{(16-SPRITE_DEPTH_BITS){1'b0}}, dst};
      LEN_ADDR:  rd_mux = {5'd0, len};
      CTRL_ADDR: rd_mux = {13'd0, wait_vblank, 1'b0, busy};
      default:   rd_mux = 16'd0;
    endcase
  end

  // One-cycle readback latency, matching the other memory-mapped registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      dma_memdata <= 16'd0;
    end else begin
      dma_memdata <= rd_mux;
    end
  end

endmodule

// File: rtl/sprite_dma.sv
// Sprite DMA engine: copies LEN words from main memory (starting at SRC)
// into sprite object RAM (starting at DST), optionally deferred to vblank.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   memaddr/memwrite/writedata  CPU data bus (register access)
//   dma_memdata                 register readback
//   vbright                     1 = active display, 0 = vblank
//   stall                       CPU hold while the DMA owns the buses
//   busy                        transfer pending or active
//   mem_addr/mem_en/mem_rdata   main memory port A (1-cycle read latency)
//   sprite_addr/we/wdata        sprite object RAM write port
//   done                        one-cycle completion pulse
module sprite_dma
  import gpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  memaddr,
  input  logic                         memwrite,
  input  logic [15:0]                  writedata,
  output logic [15:0]                  dma_memdata,
  input  logic                         vbright,
  output logic                         stall,
  output logic                         busy,
  output logic [15:0]                  mem_addr,
  output logic                         mem_en,
  input  logic [15:0]                  mem_rdata,
  output logic [SPRITE_DEPTH_BITS-1:0] sprite_addr,
  output logic                         sprite_we,
  output logic [15:0]                  sprite_wdata,
  output logic                         done
);

  dma_state_e                   state, state_nx;
  logic [15:0]                  rd_ptr, rd_ptr_nx;
  logic [SPRITE_DEPTH_BITS-1:0] wr_ptr, wr_ptr_nx;
  logic [10:0]                  cnt, cnt_nx;

  logic [15:0]                  src;
  logic [SPRITE_DEPTH_BITS-1:0] dst;
  logic [10:0]                  len;
  logic                         wait_vblank;
  logic                         ctrl_wr;
  logic                         idle, start, abort, stall_nx;

  dma_regs u_regs (
    .clk         (clk),
    .rst         (rst),
    .memaddr     (memaddr),
    .memwrite    (memwrite),
    .writedata   (writedata),
    .idle        (idle),
    .busy        (busy),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .wait_vblank (wait_vblank),
    .ctrl_wr     (ctrl_wr),
    .dma_memdata (dma_memdata)
  );

  assign idle  = (state == ST_IDLE);
  assign start = ctrl_wr && idle && writedata[CTRL_START_BIT];
  assign abort = ctrl_wr && (state == ST_WAIT_VB) && writedata[CTRL_ABORT_BIT];

  // Next-state and pointer update logic
  always_comb begin
    state_nx  = state;
    rd_ptr_nx = rd_ptr;
    wr_ptr_nx = wr_ptr;
    cnt_nx    = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // src cannot change until the FSM is back in IDLE, so load it now
          rd_ptr_nx = src;
          if (len == 11'd0) begin
            state_nx = ST_FINISH;
          end else if (writedata[CTRL_WAIT_VB_BIT]) begin
            state_nx = ST_WAIT_VB;
          end else begin
            state_nx = ST_PRIME;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT_VB: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (!vbright) begin
          state_nx = ST_PRIME;
        end else begin
          state_nx = ST_WAIT_VB;
        end
      end
      ST_PRIME: begin
        // first read issued this cycle; the next address goes out with write 0
        state_nx  = ST_STREAM;
        cnt_nx    = len;
        wr_ptr_nx = dst;
        rd_ptr_nx = rd_ptr + 16'd1;
      end
      ST_STREAM: begin
        wr_ptr_nx = wr_ptr + 10'd1;
        rd_ptr_nx = rd_ptr + 16'd1;
        cnt_nx    = cnt - 11'd1;
        if (cnt == 11'd1) begin
          state_nx = ST_FINISH;
        end else begin
          state_nx = ST_STREAM;
        end
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign stall_nx = (state_nx == ST_PRIME) || (state_nx == ST_STREAM);

  // State, pointers and bus outputs; outputs are decoded from the next state
  // so they are registered yet aligned with the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rd_ptr      <= 16'd0;
      wr_ptr      <= {SPRITE_DEPTH_BITS{1'b0}};
      cnt         <= 11'd0;
      stall       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= 16'd0;
      sprite_we   <= 1'b0;
      sprite_addr <= {SPRITE_DEPTH_BITS{1'b0}};
    end else begin
      state       <= state_nx;
      rd_ptr      <= rd_ptr_nx;
      wr_ptr      <= wr_ptr_nx;
      cnt         <= cnt_nx;
      stall       <= stall_nx;
      busy        <= stall_nx || (state_nx == ST_WAIT_VB);
      done        <= (state_nx == ST_FINISH);
      // no read is needed for the word after the last one
      mem_en      <= (state_nx == ST_PRIME) ||
                     ((state_nx == ST_STREAM) && (cnt_nx > 11'd1));
      mem_addr    <= stall_nx ? rd_ptr_nx : 16'd0;
      sprite_we   <= (state_nx == ST_STREAM);
      sprite_addr <= (state_nx == ST_STREAM) ? wr_ptr_nx : {SPRITE_DEPTH_BITS{1'b0}};
    end
  end

  // Read data arrives one cycle after its address, exactly in the write cycle
  assign sprite_wdata = sprite_we ? mem_rdata : 16'd0;

endmodule

// File: tb/tb_sprite_dma.sv
module tb_sprite_dma;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] memaddr = 16'd0;
  logic        memwrite = 1'b0;
  logic [15:0] writedata = 16'd0;
  logic [15:0] dma_memdata;
  logic        vbright = 1'b0;
  logic        stall, busy, mem_en, sprite_we, done;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'd0;
  logic [9:0]  sprite_addr;
  logic [15:0] sprite_wdata;

  always #5 clk = ~clk;

  sprite_dma dut (
    .clk(clk), .rst(rst), .memaddr(memaddr), .memwrite(memwrite),
    .writedata(writedata), .dma_memdata(dma_memdata), .vbright(vbright),
    .stall(stall), .busy(busy), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .sprite_addr(sprite_addr), .sprite_we(sprite_we),
    .sprite_wdata(sprite_wdata), .done(done)
  );

  logic [15:0] main_mem   [0:65535];
  logic [15:0] sprite_ram [0:1023];
  logic [15:0] exp_spr    [0:1023];

  int checks = 0;
  int errors = 0;

  // Environment memories: synchronous-read main memory, sprite RAM write port
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= main_mem[mem_addr];
    if (sprite_we) sprite_ram[sprite_addr] <= sprite_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    memaddr = a; writedata = d; memwrite = 1'b1;
    tick();
    memwrite = 1'b0; memaddr = 16'd0; writedata = 16'd0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    memaddr = a;
    tick();
    v = dma_memdata;
    memaddr = 16'd0;
  endtask

  // Reference: length field is bits [10:0], capped at a full sprite RAM
  function automatic int spec_len(input logic [15:0] raw);
    int v;
    v = int'(raw[10:0]);
    return (v > 1024) ? 1024 : v;
  endfunction

  // Reference copy: word k of the block goes from src+k to dst+k with wrap
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int k = 0; k < n; k++)
      exp_spr[(int'(d[9:0]) + k) % 1024] = main_mem[(int'(s) + k) % 65536];
  endtask

  function automatic int sprite_diffs();
    int c = 0;
    for (int i = 0; i < 1024; i++)
      if (sprite_ram[i] !== exp_spr[i]) c++;
    return c;
  endfunction

  // Program a transfer, start it, and check cycle-by-cycle handshake timing
  // plus the resulting sprite RAM image.
  task automatic run_xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input bit wt, input int wcyc, input bit rnd_vb);
    int n, bad, bad_wait;
    logic e_stall, e_busy, e_done, e_we;
    n = spec_len(l); bad = 0; bad_wait = 0;
    wr(SRC_ADDR, s); wr(DST_ADDR, d); wr(LEN_ADDR, l);
    vbright = wt;
    wr(CTRL_ADDR, wt ? 16'h0003 : 16'h0001);
    if (wt && n > 0) begin
      for (int j = 0; j < wcyc; j++) begin
        if (busy !== 1'b1 || stall !== 1'b0 || done !== 1'b0 || sprite_we !== 1'b0) bad_wait++;
        tick();
      end
      chk({tag, " wait_vb hold"}, bad_wait, 0);
      vbright = 1'b0;
      tick();
    end
    // sample i = 0 is the first cycle after start (or after vblank was seen)
    for (int i = 0; i <= n + 2; i++) begin
      e_stall = (n > 0) && (i <= n);
      e_busy  = e_stall;
      e_done  = (n == 0) ? (i == 0) : (i == n + 1);
      e_we    = (n > 0) && (i >= 1) && (i <= n);
      if ({stall, busy, done, sprite_we} !== {e_stall, e_busy, e_done, e_we}) bad++;
      if (rnd_vb) vbright = 1'($urandom_range(0, 1));
      tick();
    end
    vbright = 1'b0;
    chk({tag, " timing"}, bad, 0);
    model_copy(s, d, n);
    chk({tag, " sprite ram"}, sprite_diffs(), 0);
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst_wr;
    logic [15:0] len_wr;
    logic [15:0] dst_rb;
    logic [15:0] len_rb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] v;
    int cnt;

    vecs[0] = '{16'h0100, 16'h0010, 16'h0004, 16'h0010, 16'h0004};
    vecs[1] = '{16'h0200, 16'h03FE, 16'h0004, 16'h03FE, 16'h0004};
    vecs[2] = '{16'hFFFE, 16'hFC40, 16'h0005, 16'h0040, 16'h0005};
    vecs[3] = '{16'h0300, 16'h0020, 16'h0000, 16'h0020, 16'h0000};
    vecs[4] = '{16'h1000, 16'h0123, 16'h07FF, 16'h0123, 16'h0400};
    vecs[5] = '{16'h2000, 16'h02AB, 16'hF801, 16'h02AB, 16'h0001};

    for (int i = 0; i < 65536; i++) main_mem[i] = 16'($urandom);
    for (int i = 0; i < 1024; i++) begin
      sprite_ram[i] = 16'd0;
      exp_spr[i]    = 16'd0;
    end

    // reset behaviour
    rst = 1'b0;
    repeat (3) tick();
    chk("reset ctl outs", {stall, busy, done, mem_en, sprite_we}, 5'b0);
    chk("reset addrs", {mem_addr, 6'd0, sprite_addr}, 32'd0);
    chk("reset readback", dma_memdata, 16'd0);
    rst = 1'b1;
    rd(SRC_ADDR, v); chk("reset src reg", v, 16'd0);
    rd(CTRL_ADDR, v); chk("reset ctrl reg", v, 16'd0);

    // table-driven transfers with register readback
    for (int t = 0; t < 6; t++) begin
      run_xfer($sformatf("vec%0d", t), vecs[t].src, vecs[t].dst_wr, vecs[t].len_wr, 1'b0, 0, 1'b0);
      rd(SRC_ADDR, v);  chk($sformatf("vec%0d src rb", t), v, vecs[t].src);
      rd(DST_ADDR, v);  chk($sformatf("vec%0d dst rb", t), v, vecs[t].dst_rb);
      rd(LEN_ADDR, v);  chk($sformatf("vec%0d len rb", t), v, vecs[t].len_rb);
      rd(CTRL_ADDR, v); chk($sformatf("vec%0d ctrl rb", t), v, 16'h0000);
    end

    // deferred start: held for 50 cycles of active display
    run_xfer("vblank", 16'h0800, 16'h0200, 16'h0003, 1'b1, 50, 1'b0);

    // randomized transfers, display toggling during the copy
    for (int r = 0; r < 12; r++) begin
      run_xfer($sformatf("rnd%0d", r), 16'($urandom), 16'($urandom),
               16'($urandom_range(0, 48)), ($urandom_range(0, 3) == 0),
               int'($urandom_range(1, 6)), 1'b1);
    end

    // abort while waiting for vblank
    wr(SRC_ADDR, 16'h0900); wr(DST_ADDR, 16'h0050); wr(LEN_ADDR, 16'h0005);
    vbright = 1'b1;
    wr(CTRL_ADDR, 16'h0003);
    rd(CTRL_ADDR, v); chk("wait ctrl rb", v, 16'h0005);
    chk("wait busy/stall", {busy, stall}, 2'b10);
    wr(CTRL_ADDR, 16'h0004);
    chk("abort outs", {busy, stall, done}, 3'b000);
    vbright = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || sprite_we || stall || busy) cnt++;
      tick();
    end
    chk("abort quiet", cnt, 0);
    chk("abort sprite ram", sprite_diffs(), 0);

    // writes ignored while busy, CTRL shows busy mid-transfer
    wr(SRC_ADDR, 16'h0A00); wr(DST_ADDR, 16'h0100); wr(LEN_ADDR, 16'h0008);
    wr(CTRL_ADDR, 16'h0001);
    wr(SRC_ADDR, 16'hDEAD);
    rd(CTRL_ADDR, v); chk("busy ctrl rb", v, 16'h0001);
    repeat (12) tick();
    rd(SRC_ADDR, v); chk("src locked", v, 16'h0A00);
    model_copy(16'h0A00, 16'h0100, 8);
    chk("locked sprite ram", sprite_diffs(), 0);

    // reset in the middle of streaming
    wr(SRC_ADDR, 16'h0C00); wr(DST_ADDR, 16'h0300); wr(LEN_ADDR, 16'd20);
    wr(CTRL_ADDR, 16'h0001);
    repeat (5) tick();
    chk("mid stream we", sprite_we, 1'b1);
    rst = 1'b0;
    tick();
    chk("rst ctl outs", {stall, busy, done, mem_en, sprite_we}, 5'b0);
    chk("rst addrs", {mem_addr, 6'd0, sprite_addr}, 32'd0);
    chk("rst data outs", {dma_memdata, sprite_wdata}, 32'd0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || sprite_we || stall || busy) cnt++;
      tick();
    end
    chk("post rst quiet", cnt, 0);
    rd(LEN_ADDR, v); chk("post rst len", v, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
